// File: rtl/reg_dump_sequencer_pkg.sv
// Shared register-file geometry and the dump sequencer's state encoding.
package reg_dump_sequencer_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int REG_COUNT  = 32;

    typedef enum logic [2:0] {
        RDS_IDLE    = 3'd0,
        RDS_READ    = 3'd1,
        RDS_SEND_LO = 3'd2,
        RDS_SEND_HI = 3'd3,
        RDS_DONE    = 3'd4
    } rdsState_t;

endpackage

// File: rtl/reg_dump_sequencer_if.sv
// Bus bundle of the dump sequencer: regfile read port pair plus the outgoing beat stream.
// master = sequencer side, slave = regfile/consumer side.
interface reg_dump_sequencer_if import reg_dump_sequencer_pkg::*; #(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) ();

    logic [ADDR_W-1:0] ReadRegister1;
    logic [ADDR_W-1:0] ReadRegister2;
    logic [DATA_W-1:0] ReadData1;
    logic [DATA_W-1:0] ReadData2;
    logic              OutValid;
    logic              OutReady;
    logic [ADDR_W-1:0] OutAddr;
    logic [DATA_W-1:0] OutData;

    modport master (
        output ReadRegister1, ReadRegister2,
        input  ReadData1, ReadData2,
        output OutValid, OutAddr, OutData,
        input  OutReady
    );

    modport slave (
        input  ReadRegister1, ReadRegister2,
        output ReadData1, ReadData2,
        input  OutValid, OutAddr, OutData,
        output OutReady
    );

endinterface

// File: rtl/reg_dump_sequencer.sv
// Register dump sequencer: reads the register file two registers per pass and streams
// (addr, data) beats over a valid/ready port, holding off regfile writes while active.
module reg_dump_sequencer import reg_dump_sequencer_pkg::*; #(
    parameter int NUM_REGS  = REG_COUNT,
    parameter int ADDR_W    = REG_ADDR_W,
    parameter int DATA_W    = REG_DATA_W,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 Start,
    input  logic                 Abort,
    reg_dump_sequencer_if.master bus,
    output logic                 HoldWrite,
    output logic                 Busy,
    output logic                 Done
);

    localparam int             K_W    = ADDR_W - 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(NUM_REGS / 2 - 1);

    rdsState_t         state, stateNext;
    logic [K_W-1:0]    pairIdx, pairIdxNext;
    logic [DATA_W-1:0] loBuf, hiBuf;
    logic [ADDR_W-1:0] rdAddr1, rdAddr2;
    logic              outValid;
    logic [ADDR_W-1:0] outAddr;
    logic [DATA_W-1:0] outData;
    logic              handshake;

    // Register number of the even (hi=0) or odd (hi=1) member of pair k.
    function automatic logic [ADDR_W-1:0] pairAddr(input logic [K_W-1:0] k, input logic hi);
        return {k, hi};
    endfunction

    assign handshake = outValid && bus.OutReady;

    // Next-state and pair-index selection; Abort overrides everything outside IDLE.
    always_comb begin
        stateNext   = state;
        pairIdxNext = pairIdx;
        unique case (state)
            RDS_IDLE: begin
                if (Start && !Abort) begin
                    stateNext   = RDS_READ;
                    pairIdxNext = '0;
                end
            end
            RDS_READ: begin
                stateNext = (SKIP_ZERO && pairIdx == '0) ? RDS_SEND_HI : RDS_SEND_LO;
            end
            RDS_SEND_LO: begin
                if (handshake) stateNext = RDS_SEND_HI;
            end
            RDS_SEND_HI: begin
                if (handshake) begin
                    if (pairIdx == K_LAST) begin
                        stateNext = RDS_DONE;
                    end else begin
                        stateNext   = RDS_READ;
                        pairIdxNext = pairIdx + 1'b1;
                    end
                end
            end
            RDS_DONE: stateNext = RDS_IDLE;
            default:  stateNext = RDS_IDLE;
        endcase
        if (state != RDS_IDLE && Abort) begin
            stateNext   = RDS_IDLE;
            pairIdxNext = pairIdx;
        end
    end

    // State and pair index; read addresses are registered so they are valid for all of READ.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state   <= RDS_IDLE;
            pairIdx <= '0;
            rdAddr1 <= '0;
            rdAddr2 <= '0;
        end else begin
            state   <= stateNext;
            pairIdx <= pairIdxNext;
            rdAddr1 <= (stateNext == RDS_READ) ? pairAddr(pairIdxNext, 1'b0) : '0;
            rdAddr2 <= (stateNext == RDS_READ) ? pairAddr(pairIdxNext, 1'b1) : '0;
        end
    end

    // Snapshot both regfile read ports at the end of READ.
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            loBuf <= '0;
            hiBuf <= '0;
        end else if (state == RDS_READ) begin
            loBuf <= bus.ReadData1;
            hiBuf <= bus.ReadData2;
        end
    end

    // Beat presentation: held purely by state, so it stays stable until the handshake.
    always_comb begin
        outValid = 1'b0;
        outAddr  = '0;
        outData  = '0;
        if (state == RDS_SEND_LO) begin
            outValid = 1'b1;
            outAddr  = pairAddr(pairIdx, 1'b0);
            outData  = loBuf;
        end else if (state == RDS_SEND_HI) begin
            outValid = 1'b1;
            outAddr  = pairAddr(pairIdx, 1'b1);
            outData  = hiBuf;
        end
    end

    assign bus.ReadRegister1 = rdAddr1;
    assign bus.ReadRegister2 = rdAddr2;
    assign bus.OutValid      = outValid;
    assign bus.OutAddr       = outAddr;
    assign bus.OutData       = outData;
    assign Busy              = (state != RDS_IDLE);
    assign HoldWrite         = Busy;
    assign Done              = (state == RDS_DONE);

endmodule

// File: tb/tb_reg_dump_sequencer.sv
// Bench for reg_dump_sequencer: one instance dumping all registers, one skipping R0,
// both reading a shared register file whose writes are gated by HoldWrite.
module tb_reg_dump_sequencer;
    import reg_dump_sequencer_pkg::*;

    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 32;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    logic [1:0]    start = '0, abortReq = '0, ready = '0;
    logic [1:0]    hold, busy, done, valid;
    logic [AW-1:0] oAddr [2];
    logic [DW-1:0] oData [2];
    logic [AW-1:0] rr1 [2];
    logic [AW-1:0] rr2 [2];

    logic [DW-1:0] rf [NR];
    logic [DW-1:0] golden [NR];
    logic          wrEn = 1'b0;
    logic [AW-1:0] wrAddr = '0;
    logic [DW-1:0] wrData = '0;

    int total = 0;
    int bad   = 0;

    reg_dump_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) ifA ();
    reg_dump_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) ifB ();

    reg_dump_sequencer #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1'b0)) dutA (
        .Clk(Clk), .Rst_n(Rst_n), .Start(start[0]), .Abort(abortReq[0]), .bus(ifA),
        .HoldWrite(hold[0]), .Busy(busy[0]), .Done(done[0]));

    reg_dump_sequencer #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .SKIP_ZERO(1'b1)) dutB (
        .Clk(Clk), .Rst_n(Rst_n), .Start(start[1]), .Abort(abortReq[1]), .bus(ifB),
        .HoldWrite(hold[1]), .Busy(busy[1]), .Done(done[1]));

    // Register file: R0 reads as zero, writes blocked while any sequencer holds.
    assign ifA.ReadData1 = (ifA.ReadRegister1 == '0) ? '0 : rf[ifA.ReadRegister1];
    assign ifA.ReadData2 = (ifA.ReadRegister2 == '0) ? '0 : rf[ifA.ReadRegister2];
    assign ifB.ReadData1 = (ifB.ReadRegister1 == '0) ? '0 : rf[ifB.ReadRegister1];
    assign ifB.ReadData2 = (ifB.ReadRegister2 == '0) ? '0 : rf[ifB.ReadRegister2];
    always @(posedge Clk) begin
        if (wrEn && !(hold[0] || hold[1]) && wrAddr != '0) rf[wrAddr] <= wrData;
    end

    assign ifA.OutReady = ready[0];
    assign ifB.OutReady = ready[1];
    assign valid = {ifB.OutValid, ifA.OutValid};
    assign oAddr[0] = ifA.OutAddr;  assign oAddr[1] = ifB.OutAddr;
    assign oData[0] = ifA.OutData;  assign oData[1] = ifB.OutData;
    assign rr1[0] = ifA.ReadRegister1;  assign rr1[1] = ifB.ReadRegister1;
    assign rr2[0] = ifA.ReadRegister2;  assign rr2[1] = ifB.ReadRegister2;

    task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic checkIdle(input int d, input string tag);
        checkVal({tag, ":busy"},  64'(busy[d]),  64'(0));
        checkVal({tag, ":hold"},  64'(hold[d]),  64'(0));
        checkVal({tag, ":done"},  64'(done[d]),  64'(0));
        checkVal({tag, ":valid"}, 64'(valid[d]), 64'(0));
        checkVal({tag, ":addr"},  64'(oAddr[d]), 64'(0));
        checkVal({tag, ":data"},  64'(oData[d]), 64'(0));
        checkVal({tag, ":rr"},    64'({rr1[d], rr2[d]}), 64'(0));
    endtask

    // Fill R1..R31 through the write port, either Rn=n or random values.
    task automatic preload(input bit incr);
        golden[0] = '0;
        for (int n = 1; n < NR; n++) begin
            wrEn   = 1'b1;
            wrAddr = AW'(n);
            wrData = incr ? DW'(n) : DW'($urandom);
            golden[n] = wrData;
            tick();
        end
        wrEn = 1'b0;
    endtask

    // One dump on sequencer d. readyMode: 0 always ready, 1 pattern 1,0,0, 2 random.
    // abortAfter>0 aborts after that many accepted beats; resetAt>=0 pulses reset when that
    // address is on the port; doWrite hammers R31 during the dump.
    task automatic dumpRun(input int d, input int readyMode, input int abortAfter,
                           input int resetAt, input bit doWrite, input bit skip, input string nm);
        logic [AW-1:0] expAddr [$];
        logic [DW-1:0] expData [$];
        int cyc, accepted, pat;
        bit finished, prevStall;
        logic [AW-1:0] prevAddr;
        logic [DW-1:0] prevData;
        for (int a = 0; a < NR; a++) begin
            if (!(skip && a == 0)) begin
                expAddr.push_back(AW'(a));
                expData.push_back(golden[a]);
            end
        end
        cyc = 1; accepted = 0; pat = 0; finished = 1'b0; prevStall = 1'b0;
        prevAddr = '0; prevData = '0;
        start[d] = 1'b1;
        tick();
        start[d] = 1'b0;
        if (doWrite) begin
            wrEn = 1'b1; wrAddr = AW'(31); wrData = 32'hDEAD_BEEF;
        end
        while (!finished && cyc < 2000) begin
            case (readyMode)
                0:       ready[d] = 1'b1;
                1:       ready[d] = (pat % 3 == 0);
                default: ready[d] = ($urandom_range(0, 9) < 6);
            endcase
            pat++;
            if (readyMode != 0) start[d] = ($urandom_range(0, 7) == 0);
            @(negedge Clk);
            if (prevStall) begin
                checkVal({nm, ":holdValid"}, 64'(valid[d]), 64'(1));
                checkVal({nm, ":holdAddr"},  64'(oAddr[d]), 64'(prevAddr));
                checkVal({nm, ":holdData"},  64'(oData[d]), 64'(prevData));
            end
            if (valid[d]) checkVal({nm, ":rrIdle"}, 64'({rr1[d], rr2[d]}), 64'(0));
            if (done[d]) begin
                finished = 1'b1;
                checkVal({nm, ":leftAtDone"}, 64'(expAddr.size()), 64'(0));
                checkVal({nm, ":doneBusy"}, 64'(busy[d]), 64'(1));
                if (readyMode == 0)
                    checkVal({nm, ":doneCycle"}, 64'(cyc), 64'(NR / 2 * 3 + 1 - (skip ? 1 : 0)));
            end else if (valid[d] && ready[d]) begin
                checkVal({nm, ":beatAvail"}, 64'(expAddr.size() != 0), 64'(1));
                if (expAddr.size() != 0) begin
                    checkVal({nm, ":addr"}, 64'(oAddr[d]), 64'(expAddr.pop_front()));
                    checkVal({nm, ":data"}, 64'(oData[d]), 64'(expData.pop_front()));
                end
                accepted++;
            end
            prevStall = valid[d] && !ready[d];
            prevAddr  = oAddr[d];
            prevData  = oData[d];
            if (!finished && resetAt >= 0 && valid[d] && oAddr[d] == AW'(resetAt)) begin
                Rst_n = 1'b0;
                start[d] = 1'b1;
                @(posedge Clk);
                #1;
                Rst_n = 1'b1;
                start[d] = 1'b0;
                @(negedge Clk);
                checkIdle(d, {nm, ":rst"});
                tick();
                @(negedge Clk);
                checkVal({nm, ":rstStartIgnored"}, 64'(busy[d]), 64'(0));
                finished = 1'b1;
            end else if (!finished && abortAfter > 0 && accepted == abortAfter) begin
                tick();
                abortReq[d] = 1'b1;
                start[d] = 1'b0;
                ready[d] = 1'($urandom_range(0, 1));
                tick();
                abortReq[d] = 1'b0;
                ready[d] = 1'b0;
                @(negedge Clk);
                checkIdle(d, {nm, ":abort"});
                tick();
                @(negedge Clk);
                checkVal({nm, ":abortNoDone"}, 64'(done[d]), 64'(0));
                finished = 1'b1;
            end else if (!finished) begin
                tick();
                cyc++;
            end
        end
        checkVal({nm, ":finished"}, 64'(finished), 64'(1));
        start[d] = 1'b0;
        if (done[d]) begin
            tick();
            wrEn = 1'b0;
            ready[d] = 1'b0;
            @(negedge Clk);
            checkVal({nm, ":donePulse"}, 64'(done[d]), 64'(0));
            checkVal({nm, ":busyAfter"}, 64'(busy[d]), 64'(0));
            checkVal({nm, ":holdAfter"}, 64'(hold[d]), 64'(0));
        end
        wrEn = 1'b0;
        ready[d] = 1'b0;
        tick();
    endtask

    initial begin
        // Reset with Start asserted: nothing may move.
        start = 2'b11;
        repeat (3) tick();
        @(negedge Clk);
        checkIdle(0, "reset0");
        checkIdle(1, "reset1");
        start = 2'b00;
        Rst_n = 1'b1;
        tick();

        preload(1'b1);
        dumpRun(0, 0, 0, -1, 1'b0, 1'b0, "t1");
        dumpRun(1, 0, 0, -1, 1'b0, 1'b1, "t2");
        dumpRun(0, 1, 0, -1, 1'b0, 1'b0, "t3");
        dumpRun(0, 0, 5, -1, 1'b0, 1'b0, "t4abort");
        dumpRun(0, 0, 0, -1, 1'b0, 1'b0, "t4restart");
        dumpRun(0, 0, 0, -1, 1'b1, 1'b0, "t5");
        checkVal("t5:r31", 64'(rf[31]), 64'(golden[31]));

        // Start and Abort together in IDLE stay IDLE.
        start[0] = 1'b1;
        abortReq[0] = 1'b1;
        tick();
        start[0] = 1'b0;
        abortReq[0] = 1'b0;
        @(negedge Clk);
        checkVal("startAbortIdle", 64'(busy[0]), 64'(0));
        tick();

        dumpRun(0, 0, 0, 7, 1'b0, 1'b0, "t6");
        dumpRun(0, 0, 0, -1, 1'b0, 1'b0, "t6after");

        for (int i = 0; i < 6; i++) begin
            preload(1'b0);
            dumpRun(i % 2, 2, ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 0,
                    -1, 1'b0, (i % 2) == 1, "rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
